// File: rtl/alarm_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm sequencing stage:
//   - state_e        : 2-bit ring state (IDLE / RING / SNOOZE), also the
//                      encoding presented on the state_o display port
//   - *_DEF          : default timing and snooze-limit values
//   - time_match()   : full minute/hour/day equality of time vs. alarm
// ---------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 540;
  localparam int MAX_SNOOZE_DEF = 3;

  // True when the running time equals the programmed alarm time and day.
  function automatic logic time_match(
    input logic [6:0] tmin,
    input logic [6:0] thrs,
    input logic [6:0] tday,
    input logic [6:0] amin,
    input logic [6:0] ahrs,
    input logic [6:0] aday
  );
    return (tmin == amin) && (thrs == ahrs) && (tday == aday);
  endfunction

endpackage

// File: rtl/alarm_snooze_ctrl_rise_det.sv
// ---------------------------------------------------------------------------
// rise_det
// One-bit rising-edge detector. The history flop is loaded with RST_VAL on
// reset; a history of 1 means a level that is already high when reset is
// released is not reported as a new edge.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous reset, active-low
//   d     in   level to watch
//   rise  out  d & !d_previous (combinational)
// ---------------------------------------------------------------------------
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // History follows the input every cycle.
  always_comb begin
    prev_d = d;
  end

  // History register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_snooze_ctrl
// Turns the raw time==alarm condition into a managed ring: the buzzer rings
// for RING_SEC seconds, can be snoozed up to MAX_SNOOZE times (each snooze
// re-rings after SNOOZE_SEC seconds), and can be dismissed at any time.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   sec_tick    in   one-cycle strobe per elapsed second
//   tmin/thrs/tday in  running time (7 bits each)
//   amin/ahrs/aday in  alarm time (7 bits each)
//   alarm_on    in   alarm armed (level)
//   snooze      in   snooze button (level, debounced)
//   dismiss     in   dismiss button (level, debounced)
//   buzz        out  buzzer drive, decoded from the state register
//   state_o     out  0=IDLE 1=RING 2=SNOOZE
//   snooze_cnt  out  snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic [6:0] tday,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic [6:0] aday,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzz,
  output logic [1:0] state_o,
  output logic [2:0] snooze_cnt
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SEC);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SEC);
  localparam logic [RW-1:0] RING_ONE    = RW'(1);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);
  localparam logic [2:0]    SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_e        state_q, state_d;
  logic [RW-1:0] ring_tmr_q, ring_tmr_d;
  logic [SW-1:0] snz_tmr_q, snz_tmr_d;
  logic [2:0]    cnt_q, cnt_d;

  logic match;
  logic match_rise;
  logic snooze_rise;
  logic dismiss_rise;
  logic abort;

  assign match = time_match(tmin, thrs, tday, amin, ahrs, aday);

  // Edge histories reset to 1 so that time and alarm both sitting at
  // 00:00 day 0 out of reset (or buttons held through reset) are not edges.
  rise_det #(.RST_VAL(1'b1)) u_match_rise (
    .clk   (clk),
    .rst_n (rst),
    .d     (match),
    .rise  (match_rise)
  );

  rise_det #(.RST_VAL(1'b1)) u_snooze_rise (
    .clk   (clk),
    .rst_n (rst),
    .d     (snooze),
    .rise  (snooze_rise)
  );

  rise_det #(.RST_VAL(1'b1)) u_dismiss_rise (
    .clk   (clk),
    .rst_n (rst),
    .d     (dismiss),
    .rise  (dismiss_rise)
  );

  // Disarming or dismissing ends the event from any active state and
  // outranks a simultaneous snooze press or second tick.
  assign abort = !alarm_on || dismiss_rise;

  // Next-state, timer and snooze-count computation.
  always_comb begin
    state_d    = state_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        ring_tmr_d = '0;
        snz_tmr_d  = '0;
        // Only a rising match starts an event; a match already held when
        // the alarm is armed is ignored.
        if (match_rise && alarm_on) begin
          state_d    = ST_RING;
          ring_tmr_d = RING_LOAD;
          cnt_d      = 3'd0;
        end else begin
          cnt_d      = cnt_q;
        end
      end

      ST_RING: begin
        snz_tmr_d = '0;
        if (abort) begin
          state_d    = ST_IDLE;
          ring_tmr_d = '0;
          cnt_d      = 3'd0;
        end else if (snooze_rise && (cnt_q < SNOOZE_MAX)) begin
          state_d    = ST_SNOOZE;
          ring_tmr_d = '0;
          snz_tmr_d  = SNOOZE_LOAD;
          cnt_d      = cnt_q + 3'd1;
        end else if (sec_tick) begin
          // A snooze press past the limit falls through to here and is
          // ignored; the ring keeps timing out normally.
          if (ring_tmr_q <= RING_ONE) begin
            state_d    = ST_IDLE;
            ring_tmr_d = '0;
            cnt_d      = 3'd0;
          end else begin
            ring_tmr_d = ring_tmr_q - RING_ONE;
          end
        end else begin
          ring_tmr_d = ring_tmr_q;
        end
      end

      ST_SNOOZE: begin
        ring_tmr_d = '0;
        if (abort) begin
          state_d   = ST_IDLE;
          snz_tmr_d = '0;
          cnt_d     = 3'd0;
        end else if (sec_tick) begin
          if (snz_tmr_q <= SNOOZE_ONE) begin
            state_d    = ST_RING;
            snz_tmr_d  = '0;
            ring_tmr_d = RING_LOAD;
          end else begin
            snz_tmr_d = snz_tmr_q - SNOOZE_ONE;
          end
        end else begin
          snz_tmr_d = snz_tmr_q;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        ring_tmr_d = '0;
        snz_tmr_d  = '0;
        cnt_d      = 3'd0;
      end
    endcase
  end

  // State, timer and snooze-count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs come straight from registers so reset silences the buzzer
  // without waiting for a clock.
  assign buzz       = (state_q == ST_RING);
  assign state_o    = state_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
module tb_alarm_snooze_ctrl;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic [6:0] tmin, thrs, tday;
  logic [6:0] amin, ahrs, aday;
  logic       alarm_on, snooze, dismiss;
  logic       buzz;
  logic [1:0] state_o;
  logic [2:0] snooze_cnt;

  int checks = 0;
  int errors = 0;

  alarm_snooze_ctrl #(
    .RING_SEC   (5),
    .SNOOZE_SEC (3),
    .MAX_SNOOZE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .tmin       (tmin),
    .thrs       (thrs),
    .tday       (tday),
    .amin       (amin),
    .ahrs       (ahrs),
    .aday       (aday),
    .alarm_on   (alarm_on),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .buzz       (buzz),
    .state_o    (state_o),
    .snooze_cnt (snooze_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic bz, input logic [2:0] cnt);
    chk({tag, ".state"}, {30'd0, state_o}, {30'd0, st});
    chk({tag, ".buzz"}, {31'd0, buzz}, {31'd0, bz});
    chk({tag, ".cnt"}, {29'd0, snooze_cnt}, {29'd0, cnt});
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  // Break the match for one cycle and restore it, producing a fresh rise.
  task automatic retrigger();
    tmin = 7'd31;
    step();
    tmin = 7'd30;
    step();
  endtask

  initial begin
    rst = 1'b0; sec_tick = 1'b0;
    tmin = 7'd0; thrs = 7'd0; tday = 7'd0;
    amin = 7'd0; ahrs = 7'd0; aday = 7'd0;
    alarm_on = 1'b1; snooze = 1'b0; dismiss = 1'b0;

    step(); step();
    chk_all("reset", 2'd0, 1'b0, 3'd0);
    rst = 1'b1;

    // 00:00 d0 on both sides out of reset must not ring.
    for (int i = 0; i < 20; i++) begin
      sec_tick = (i % 3 == 0);
      step();
      chk("idle_after_reset.buzz", {31'd0, buzz}, 32'd0);
    end
    sec_tick = 1'b0;

    // Alarm 07:30 d2, time walks 07:29 -> 07:30.
    amin = 7'd30; ahrs = 7'd7; aday = 7'd2;
    tmin = 7'd29; thrs = 7'd7; tday = 7'd2;
    step();
    chk_all("pre_match", 2'd0, 1'b0, 3'd0);
    tmin = 7'd30;
    step();
    chk_all("ring_start", 2'd1, 1'b1, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    chk_all("ring_4ticks", 2'd1, 1'b1, 3'd0);
    tick();
    chk_all("ring_timeout", 2'd0, 1'b0, 3'd0);
    step();
    chk_all("no_rering_held_match", 2'd0, 1'b0, 3'd0);

    // Snooze sequence up to the limit.
    retrigger();
    chk_all("ring2_start", 2'd1, 1'b1, 3'd0);
    snooze = 1'b1;
    step();
    chk_all("snooze1", 2'd2, 1'b0, 3'd1);
    snooze = 1'b0;
    step();
    tick(); tick();
    chk_all("snooze1_2ticks", 2'd2, 1'b0, 3'd1);
    tick();
    chk_all("rering1", 2'd1, 1'b1, 3'd1);
    // Snooze press with a simultaneous tick: tick dropped, timer loads 3.
    snooze = 1'b1; sec_tick = 1'b1;
    step();
    snooze = 1'b0; sec_tick = 1'b0;
    chk_all("snooze2", 2'd2, 1'b0, 3'd2);
    tick(); tick();
    chk_all("snooze2_2ticks", 2'd2, 1'b0, 3'd2);
    tick();
    chk_all("rering2", 2'd1, 1'b1, 3'd2);
    snooze = 1'b1;
    step();
    chk_all("snooze_over_limit", 2'd1, 1'b1, 3'd2);
    snooze = 1'b0;
    step();
    for (int i = 0; i < 4; i++) tick();
    chk_all("limit_ring_4ticks", 2'd1, 1'b1, 3'd2);
    tick();
    chk_all("limit_timeout", 2'd0, 1'b0, 3'd0);

    // Disarm during SNOOZE, then re-arm while match holds.
    retrigger();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk_all("snooze_before_disarm", 2'd2, 1'b0, 3'd1);
    alarm_on = 1'b0;
    step();
    chk_all("disarm_in_snooze", 2'd0, 1'b0, 3'd0);
    alarm_on = 1'b1;
    step(); step(); step();
    chk_all("rearm_held_match", 2'd0, 1'b0, 3'd0);

    // Snooze and dismiss together in RING: dismiss wins.
    retrigger();
    chk_all("ring3_start", 2'd1, 1'b1, 3'd0);
    snooze = 1'b1; dismiss = 1'b1;
    step();
    chk_all("snooze_and_dismiss", 2'd0, 1'b0, 3'd0);
    snooze = 1'b0; dismiss = 1'b0;
    step();

    // Plain dismiss after one snooze re-ring.
    retrigger();
    snooze = 1'b1; step(); snooze = 1'b0;
    tick(); tick(); tick();
    chk_all("rering_before_dismiss", 2'd1, 1'b1, 3'd1);
    dismiss = 1'b1;
    step();
    chk_all("dismiss_in_ring", 2'd0, 1'b0, 3'd0);
    dismiss = 1'b0;
    step();

    // Asynchronous reset in the middle of RING.
    retrigger();
    tick();
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst_ring", 2'd0, 1'b0, 3'd0);
    #1 rst = 1'b1;
    step(); step();
    chk_all("after_rst_ring", 2'd0, 1'b0, 3'd0);

    // Asynchronous reset mid-SNOOZE with the snooze timer at 2.
    retrigger();
    snooze = 1'b1; step(); snooze = 1'b0;
    tick();
    chk_all("snooze_timer2", 2'd2, 1'b0, 3'd1);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst_snooze", 2'd0, 1'b0, 3'd0);
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_all("no_ring_after_rst", 2'd0, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
